// File: rtl/clk_div_pkg.sv
// Shared divisor types and the switch-to-divisor table used by CLK_DIV_SR
// and by the clock divider that consumes its VAL_OUT word.
package clk_div_pkg;

   localparam int unsigned DIV_W = 33;
   localparam int unsigned SW_W  = 4;

   typedef logic [DIV_W-1:0] div_t;
   typedef logic [SW_W-1:0]  sw_t;

   // Divisors for a 100 MHz system clock; entry 0 parks the divider idle.
   localparam div_t DIV_TABLE [16] = '{
      div_t'(0),
      div_t'(1),
      div_t'(2),
      div_t'(4),
      div_t'(10),
      div_t'(100),
      div_t'(1_000),
      div_t'(10_000),
      div_t'(100_000),
      div_t'(500_000),
      div_t'(1_000_000),
      div_t'(5_000_000),
      div_t'(10_000_000),
      div_t'(50_000_000),
      div_t'(100_000_000),
      div_t'(64'h1_FFFF_FFFF)
   };

   function automatic div_t sw_to_div(input sw_t sw);
      return DIV_TABLE[sw];
   endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Programmable divider: one-cycle TICK_OUT every DIV_OUT enabled cycles and a
// toggled SCLK_OUT; new divisors are held pending until a period boundary.
module clk_div_counter
   import clk_div_pkg::*;
#(
   parameter int unsigned       WIDTH       = DIV_W,
   parameter logic [WIDTH-1:0]  DEFAULT_DIV = '0
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic [WIDTH-1:0] VAL_IN,
   input  logic             VAL_LD,
   output logic             PEND_OUT,
   output logic [WIDTH-1:0] DIV_OUT,
   output logic             TICK_OUT,
   output logic             SCLK_OUT
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] pend_val_q, pend_val_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             sclk_q, sclk_d;

   logic             idle;
   logic             terminal;
   logic             apply_ok;

   assign idle     = (div_q == '0);
   assign terminal = EN && !idle && (cnt_q == div_q - WIDTH'(1));
   // A load arriving on the same edge wins: the fresh value stays pending.
   assign apply_ok = pend_q && !VAL_LD;

   always_comb begin
      cnt_d      = cnt_q;
      div_d      = div_q;
      pend_val_d = pend_val_q;
      pend_d     = pend_q;
      tick_d     = 1'b0;
      sclk_d     = sclk_q;

      if (idle) begin
         cnt_d = '0;
         if (apply_ok) begin
            div_d  = pend_val_q;
            pend_d = 1'b0;
         end
      end else if (terminal) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         sclk_d = ~sclk_q;
         if (apply_ok) begin
            div_d  = pend_val_q;
            pend_d = 1'b0;
         end
      end else if (EN) begin
         cnt_d = cnt_q + WIDTH'(1);
      end

      if (VAL_LD) begin
         pend_val_d = VAL_IN;
         pend_d     = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q      <= '0;
         div_q      <= DEFAULT_DIV;
         pend_val_q <= '0;
         pend_q     <= 1'b0;
         tick_q     <= 1'b0;
         sclk_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_val_q <= pend_val_d;
         pend_q     <= pend_d;
         tick_q     <= tick_d;
         sclk_q     <= sclk_d;
      end
   end

   assign PEND_OUT = pend_q;
   assign DIV_OUT  = div_q;
   assign TICK_OUT = tick_q;
   assign SCLK_OUT = sclk_q;

endmodule

// File: tb/tb_clk_div_counter.sv
// Directed bench for clk_div_counter: a cycle model queues expected outputs at
// each rising edge; they are popped and compared on the following falling edge.
module tb_clk_div_counter;

   localparam int W = 33;

   logic         CLK = 1'b0;
   logic         RST_N;
   logic         EN;
   logic [W-1:0] VAL_IN;
   logic         VAL_LD;
   logic         PEND_OUT;
   logic [W-1:0] DIV_OUT;
   logic         TICK_OUT;
   logic         SCLK_OUT;

   clk_div_counter #(.WIDTH(W), .DEFAULT_DIV('0)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .EN       (EN),
      .VAL_IN   (VAL_IN),
      .VAL_LD   (VAL_LD),
      .PEND_OUT (PEND_OUT),
      .DIV_OUT  (DIV_OUT),
      .TICK_OUT (TICK_OUT),
      .SCLK_OUT (SCLK_OUT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic         pend;
      logic [W-1:0] div;
      logic         tick;
      logic         sclk;
   } exp_t;

   exp_t sb[$];

   logic [W-1:0] m_cnt, m_div, m_pv;
   logic         m_pend, m_tick, m_sclk;

   int n_tests = 0;
   int n_fail  = 0;
   int ticks, toggles;
   logic prev_sclk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = '0; m_div = '0; m_pv = '0;
      m_pend = 1'b0; m_tick = 1'b0; m_sclk = 1'b0;
   endtask

   // Next state from the behavioural rules, using inputs held stable across the edge.
   task automatic model_edge();
      logic [W-1:0] n_cnt, n_div, n_pv;
      logic         n_pend, n_tick, n_sclk;
      n_cnt = m_cnt; n_div = m_div; n_pv = m_pv; n_pend = m_pend;
      n_tick = 1'b0; n_sclk = m_sclk;
      if (m_div == 0) begin
         n_cnt = '0;
         if (m_pend && !VAL_LD) begin n_div = m_pv; n_pend = 1'b0; end
      end else if (EN) begin
         if (m_cnt + 1 == m_div) begin
            n_cnt = '0; n_tick = 1'b1; n_sclk = !m_sclk;
            if (m_pend && !VAL_LD) begin n_div = m_pv; n_pend = 1'b0; end
         end else begin
            n_cnt = m_cnt + 1;
         end
      end
      if (VAL_LD) begin n_pv = VAL_IN; n_pend = 1'b1; end
      m_cnt = n_cnt; m_div = n_div; m_pv = n_pv; m_pend = n_pend;
      m_tick = n_tick; m_sclk = n_sclk;
   endtask

   task automatic cycle();
      exp_t e;
      @(posedge CLK);
      model_edge();
      e.pend = m_pend; e.div = m_div; e.tick = m_tick; e.sclk = m_sclk;
      sb.push_back(e);
      @(negedge CLK);
      if (sb.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         check("pend", W'(PEND_OUT), W'(e.pend));
         check("div",  DIV_OUT,      e.div);
         check("tick", W'(TICK_OUT), W'(e.tick));
         check("sclk", W'(SCLK_OUT), W'(e.sclk));
      end
   endtask

   task automatic run_counting(input int n);
      ticks = 0; toggles = 0; prev_sclk = SCLK_OUT;
      for (int i = 0; i < n; i++) begin
         cycle();
         if (TICK_OUT) ticks++;
         if (SCLK_OUT !== prev_sclk) toggles++;
         prev_sclk = SCLK_OUT;
      end
   endtask

   task automatic load_and_wait(input logic [W-1:0] v);
      int guard;
      VAL_IN = v; VAL_LD = 1'b1;
      cycle();
      VAL_LD = 1'b0;
      guard = 0;
      while (PEND_OUT && guard < 200) begin cycle(); guard++; end
      check("apply_timeout", W'(guard < 200), W'(1));
   endtask

   initial begin
      RST_N = 1'b0; EN = 1'b1; VAL_IN = '0; VAL_LD = 1'b0;
      model_reset();
      @(negedge CLK); @(negedge CLK);
      check("rst_div",  DIV_OUT, '0);
      check("rst_pend", W'(PEND_OUT), 0);
      check("rst_tick", W'(TICK_OUT), 0);
      check("rst_sclk", W'(SCLK_OUT), 0);
      RST_N = 1'b1;

      // Idle divider: load applies on the very next edge
      VAL_IN = 4; VAL_LD = 1'b1;
      cycle();
      check("idle_pend_set", W'(PEND_OUT), 1);
      check("idle_div_hold", DIV_OUT, 0);
      VAL_LD = 1'b0;
      cycle();
      check("idle_apply_div",  DIV_OUT, 4);
      check("idle_apply_pend", W'(PEND_OUT), 0);
      run_counting(16);
      check("div4_ticks",   ticks,   4);
      check("div4_toggles", toggles, 4);
      check("div4_last_tick", W'(TICK_OUT), 1);

      // Boundary apply: load 2 mid-period, DIV_OUT waits for terminal edge
      cycle();
      VAL_IN = 2; VAL_LD = 1'b1;
      cycle();
      VAL_LD = 1'b0;
      cycle();
      check("bnd_div_hold", DIV_OUT, 4);
      check("bnd_pend",     W'(PEND_OUT), 1);
      cycle();
      check("bnd_apply_div",  DIV_OUT, 2);
      check("bnd_apply_tick", W'(TICK_OUT), 1);
      run_counting(8);
      check("div2_ticks", ticks, 4);

      // Collision: load lands exactly on a terminal edge
      for (int g = 0; g < 4 && m_cnt != m_div - 1; g++) cycle();
      VAL_IN = 6; VAL_LD = 1'b1;
      cycle();
      check("col_tick", W'(TICK_OUT), 1);
      check("col_div",  DIV_OUT, 2);
      check("col_pend", W'(PEND_OUT), 1);
      VAL_LD = 1'b0;
      cycle();
      cycle();
      check("col_apply_div", DIV_OUT, 6);
      check("col_apply_pend", W'(PEND_OUT), 0);

      // Enable hold with divisor 3
      load_and_wait(3);
      check("en_div", DIV_OUT, 3);
      cycle();
      EN = 1'b0;
      run_counting(5);
      check("en_low_ticks", ticks, 0);
      EN = 1'b1;
      cycle();
      check("en_back_no_tick", W'(TICK_OUT), 0);
      cycle();
      check("en_back_tick", W'(TICK_OUT), 1);

      // Divisor 1 then 0
      load_and_wait(1);
      run_counting(6);
      check("div1_ticks",   ticks,   6);
      check("div1_toggles", toggles, 6);
      load_and_wait(0);
      check("div0_div", DIV_OUT, 0);
      run_counting(5);
      check("div0_ticks",   ticks,   0);
      check("div0_toggles", toggles, 0);

      // Reset mid-period with divisor 5 and a pending value
      EN = 1'b0;
      VAL_IN = 5; VAL_LD = 1'b1;
      cycle();
      VAL_LD = 1'b0;
      cycle();
      check("idle_apply_en0", DIV_OUT, 5);
      EN = 1'b1;
      cycle(); cycle();
      VAL_IN = 7; VAL_LD = 1'b1;
      cycle();
      VAL_LD = 1'b0;
      #2 RST_N = 1'b0;
      model_reset();
      #1;
      check("arst_div",  DIV_OUT, 0);
      check("arst_pend", W'(PEND_OUT), 0);
      check("arst_tick", W'(TICK_OUT), 0);
      check("arst_sclk", W'(SCLK_OUT), 0);
      @(negedge CLK);
      RST_N = 1'b1;
      run_counting(4);
      check("post_rst_ticks", ticks, 0);
      check("post_rst_div", DIV_OUT, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
